// File: rtl/cpu_pkg.sv
// Shared lane geometry for the 3x16-bit ALU datapath and its store path.
// Also carries the store-unit state encoding.
package cpu_pkg;

  localparam int LANE_W    = 16;
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = LANE_W * NUM_LANES;

  localparam int LANE_C = 0;
  localparam int LANE_B = 1;
  localparam int LANE_A = 2;

  typedef enum logic [1:0] {
    IDLE,
    WA,
    WB,
    WC
  } vst_state_t;

  function automatic logic [LANE_W-1:0] lane_sel(
    input logic [VEC_W-1:0] v,
    input int               idx
  );
    return v[idx*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/vec_store_unit.sv
// Serialises a 48-bit store into one or three 16-bit acked memory writes.
// Vector stores write lanes A, B, C at base, base+1, base+2; scalar writes C.
module vec_store_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_vec,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  req_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              done
);

  vst_state_t state, state_d;

  logic [ADDR_W-1:0]   addr_d;
  logic [LANE_W-1:0]   wdata_d;
  logic [2*LANE_W-1:0] rest, rest_d;
  logic                done_d;
  logic [VEC_W-1:0]    rest_ext;

  // Lane A goes out on accept, so only lanes B and C need holding.
  assign rest_ext  = {{LANE_W{1'b0}}, rest};

  assign req_ready = (state == IDLE);
  assign stall     = ~req_ready;
  assign mem_we    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rest      <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      rest      <= rest_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    rest_d  = rest;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        addr_d  = '0;
        wdata_d = '0;
        if (req_valid) begin
          rest_d = req_data[2*LANE_W-1:0];
          addr_d = req_addr;
          if (req_vec) begin
            state_d = WA;
            wdata_d = lane_sel(req_data, LANE_A);
          end else begin
            state_d = WC;
            wdata_d = lane_sel(req_data, LANE_C);
          end
        end
      end
      WA: begin
        if (mem_ack) begin
          state_d = WB;
          addr_d  = mem_addr + ADDR_W'(1);
          wdata_d = lane_sel(rest_ext, LANE_B);
        end
      end
      WB: begin
        if (mem_ack) begin
          state_d = WC;
          addr_d  = mem_addr + ADDR_W'(1);
          wdata_d = lane_sel(rest_ext, LANE_C);
        end
      end
      WC: begin
        if (mem_ack) begin
          state_d = IDLE;
          addr_d  = '0;
          wdata_d = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vec_store_unit.sv
// Directed bench for vec_store_unit: a queue model of expected words plus
// literal cycle/address/data expectations for each scenario.
module tb_vec_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_vec = 1'b0;
  logic [15:0] req_addr = '0;
  logic [47:0] req_data = '0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        stall;
  logic        done;

  vec_store_unit #(.ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } word_t;

  word_t exp_q[$];
  bit    done_exp = 1'b0;
  bit    rst_seen = 1'b0;

  logic [15:0] wr_a[$];
  logic [15:0] wr_d[$];
  int          wr_c[$];
  int          acc_c[$];
  int          done_c[$];

  // Model: a transaction is its list of words; the unit is busy while any remain.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      done_exp = 1'b0;
      rst_seen = 1'b1;
    end else begin
      bit    ready_e;
      word_t w;
      ready_e = (exp_q.size() == 0);
      if (rst_seen) begin
        chk(mem_addr == 16'h0, "rst_addr", mem_addr, 0);
        chk(mem_wdata == 16'h0, "rst_wdata", mem_wdata, 0);
      end
      rst_seen = 1'b0;
      chk(req_ready == ready_e, "ready", req_ready, ready_e);
      chk(stall == !ready_e, "stall", stall, !ready_e);
      chk(mem_we == !ready_e, "mem_we", mem_we, !ready_e);
      chk(done == done_exp, "done", done, done_exp);
      if (!ready_e) begin
        chk(mem_addr == exp_q[0].addr, "mem_addr", mem_addr, exp_q[0].addr);
        chk(mem_wdata == exp_q[0].data, "mem_wdata", mem_wdata, exp_q[0].data);
      end
      if (done) done_c.push_back(cyc);
      done_exp = 1'b0;
      if (!ready_e && mem_ack) begin
        w = exp_q.pop_front();
        wr_a.push_back(w.addr);
        wr_d.push_back(w.data);
        wr_c.push_back(cyc);
        if (exp_q.size() == 0) done_exp = 1'b1;
      end
      if (ready_e && req_valid) begin
        acc_c.push_back(cyc);
        if (req_vec) begin
          w.addr = req_addr;         w.data = req_data[47:32]; exp_q.push_back(w);
          w.addr = req_addr + 16'd1; w.data = req_data[31:16]; exp_q.push_back(w);
          w.addr = req_addr + 16'd2; w.data = req_data[15:0];  exp_q.push_back(w);
        end else begin
          w.addr = req_addr;         w.data = req_data[15:0];  exp_q.push_back(w);
        end
      end
    end
  end

  task automatic clear_log();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    acc_c.delete(); done_c.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc_c.size() < n && k < 50) begin tick(); k++; end
    chk(acc_c.size() >= n, "accept_timeout", acc_c.size(), n);
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_c.size() < n && k < 50) begin tick(); k++; end
    chk(done_c.size() >= n, "done_timeout", done_c.size(), n);
  endtask

  task automatic do_req(input logic v, input logic [15:0] a, input logic [47:0] d);
    int n;
    n = acc_c.size() + 1;
    req_valid = 1'b1; req_vec = v; req_addr = a; req_data = d;
    wait_acc(n);
    req_valid = 1'b0; req_data = '0; req_addr = '0;
  endtask

  task automatic chk_wr(input int i, input logic [15:0] a, input logic [15:0] d,
                        input int rel);
    if (wr_a.size() > i) begin
      chk(wr_a[i] == a, "wr_addr", wr_a[i], a);
      chk(wr_d[i] == d, "wr_data", wr_d[i], d);
      chk(wr_c[i] - acc_c[0] == rel, "wr_cycle", wr_c[i] - acc_c[0], rel);
    end else begin
      chk(1'b0, "wr_missing", wr_a.size(), i + 1);
    end
  endtask

  task automatic chk_done_rel(input int i, input int rel);
    if (done_c.size() > i)
      chk(done_c[i] - acc_c[0] == rel, "done_cycle", done_c[i] - acc_c[0], rel);
    else
      chk(1'b0, "done_missing", done_c.size(), i + 1);
  endtask

  initial begin
    repeat (2) tick();
    @(negedge clk);
    chk(req_ready == 1'b1, "rst_ready", req_ready, 1);
    chk(stall == 1'b0, "rst_stall", stall, 0);
    chk(mem_we == 1'b0, "rst_we", mem_we, 0);
    chk(done == 1'b0, "rst_done", done, 0);
    tick();
    rst = 1'b0;
    tick();

    // Vector store, ack tied high
    clear_log();
    mem_ack = 1'b1;
    do_req(1'b1, 16'h0040, 48'h1111_2222_3333);
    wait_done(1);
    chk(wr_a.size() == 3, "vec_nwr", wr_a.size(), 3);
    chk_wr(0, 16'h0040, 16'h1111, 1);
    chk_wr(1, 16'h0041, 16'h2222, 2);
    chk_wr(2, 16'h0042, 16'h3333, 3);
    chk_done_rel(0, 4);
    repeat (2) tick();

    // Scalar store writes lane C only, at the base address
    clear_log();
    do_req(1'b0, 16'h0100, 48'hAAAA_BBBB_CCCC);
    wait_done(1);
    chk(wr_a.size() == 1, "sca_nwr", wr_a.size(), 1);
    chk_wr(0, 16'h0100, 16'hCCCC, 1);
    chk_done_rel(0, 2);
    repeat (2) tick();

    // Two cycles of backpressure on lane B
    clear_log();
    do_req(1'b1, 16'h0200, 48'h0A0A_0B0B_0C0C);
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    mem_ack = 1'b1;
    wait_done(1);
    chk_wr(0, 16'h0200, 16'h0A0A, 1);
    chk_wr(1, 16'h0201, 16'h0B0B, 4);
    chk_wr(2, 16'h0202, 16'h0C0C, 5);
    chk_done_rel(0, 6);
    repeat (2) tick();

    // Address wrap
    clear_log();
    do_req(1'b1, 16'hFFFF, 48'h1234_5678_9ABC);
    wait_done(1);
    chk_wr(0, 16'hFFFF, 16'h1234, 1);
    chk_wr(1, 16'h0000, 16'h5678, 2);
    chk_wr(2, 16'h0001, 16'h9ABC, 3);
    repeat (2) tick();

    // Reset while in WB
    clear_log();
    do_req(1'b1, 16'h0300, 48'hDEAD_BEEF_F00D);
    tick();
    mem_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk(mem_we == 1'b0, "mid_rst_we", mem_we, 0);
    chk(req_ready == 1'b1, "mid_rst_ready", req_ready, 1);
    chk(done == 1'b0, "mid_rst_done", done, 0);
    tick();
    mem_ack = 1'b1;
    repeat (4) tick();
    chk(wr_a.size() == 1, "mid_rst_nwr", wr_a.size(), 1);
    chk(done_c.size() == 0, "mid_rst_ndone", done_c.size(), 0);
    do_req(1'b0, 16'h0310, 48'h0000_0000_7777);
    wait_done(1);
    chk(wr_a.size() == 2, "post_rst_nwr", wr_a.size(), 2);
    if (wr_a.size() == 2) begin
      chk(wr_a[1] == 16'h0310, "post_rst_addr", wr_a[1], 16'h0310);
      chk(wr_d[1] == 16'h7777, "post_rst_data", wr_d[1], 16'h7777);
    end
    repeat (2) tick();

    // Back-to-back with ack already high while idle
    clear_log();
    mem_ack = 1'b1;
    repeat (3) tick();
    chk(wr_a.size() == 0, "idle_ack_nwr", wr_a.size(), 0);
    req_valid = 1'b1; req_vec = 1'b1;
    req_addr = 16'h0500; req_data = 48'h0101_0202_0303;
    wait_acc(1);
    req_addr = 16'h0600; req_data = 48'h0404_0505_0606;
    wait_acc(2);
    req_valid = 1'b0;
    wait_done(2);
    if (acc_c.size() == 2 && done_c.size() >= 1)
      chk(acc_c[1] == done_c[0], "b2b_accept_at_done", acc_c[1], done_c[0]);
    chk(wr_a.size() == 6, "b2b_nwr", wr_a.size(), 6);
    chk_wr(0, 16'h0500, 16'h0101, 1);
    chk_wr(1, 16'h0501, 16'h0202, 2);
    chk_wr(2, 16'h0502, 16'h0303, 3);
    chk_wr(3, 16'h0600, 16'h0404, 5);
    chk_wr(4, 16'h0601, 16'h0505, 6);
    chk_wr(5, 16'h0602, 16'h0606, 7);
    chk_done_rel(0, 4);
    chk_done_rel(1, 8);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_store_unit.md
# vec_store_unit

Memory-side writer for 48-bit vector results produced by the execute stage's three-lane (3×16-bit) ALU datapath. It accepts one store request per transaction: a 48-bit value and a word address. It serialises the request into one 16-bit write (scalar) or three 16-bit writes (vector) to the 16-bit data memory, using a per-word ack handshake. It sits between the pipeline's memory stage and data memory, and stalls the pipeline while a store is in flight.

## Interface
Parameters:
- ADDR_W, 16, word-address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request.
- req_vec  in  1  1 = vector store (3 words), 0 = scalar store (lane [15:0] only).
- req_addr  in  ADDR_W  base word address.
- req_data  in  48  lanes A=[47:32], B=[31:16], C=[15:0].
- mem_we  out  1  write strobe; held until acked.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- mem_ack  in  1  memory accepted the current word.
- stall  out  1  high while the transaction is in progress (= !req_ready).
- done  out  1  one-cycle pulse after the final word is acked.

## Operation
- States:
  - IDLE: req_ready=1, mem_we=0.
  - WA, WB, WC: one state per lane write.
- Accept: a request is accepted on an edge where req_valid & req_ready. req_addr, req_data and req_vec are captured into internal registers; inputs are don't-care afterwards.
- Transitions from IDLE:
  - vector → WA.
  - scalar → WC, which writes lane C to req_addr (not +2).
- Vector order and addresses:
  - WA: lane A at base.
  - WB: lane B at base+1.
  - WC: lane C at base+2.
  - All addresses are computed modulo 2^ADDR_W, e.g. base=16'hFFFF gives FFFF, 0000, 0001.
- In each write state:
  - mem_we=1; mem_addr and mem_wdata are stable until mem_ack.
  - On an edge with mem_ack, advance WA→WB→WC→IDLE.
  - Without mem_ack, remain in the current state.
- mem_ack while in IDLE is ignored.
- done is registered: it is 1 in the first IDLE cycle after leaving WC, and 0 otherwise.
- Reset, including mid-transaction:
  - Next state is IDLE; captured data is discarded.
  - Outputs after reset: req_ready=1, stall=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0.
  - No partial-write completion: words already acked stay written; no further words are issued.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from req_* or mem_ack to any output.
- Accept at edge 0:
  - First mem_we is visible in cycle 1.
  - With mem_ack tied high, words occupy cycles 1, 2, 3 (vector) or cycle 1 (scalar).
  - done and req_ready are high in cycle 4 (vector) or cycle 2 (scalar).
- Throughput is one new request accepted in the same cycle done is high, so back-to-back vector stores run at 4 cycles each.
- Each cycle of mem_ack=0 during a write state adds exactly one cycle of latency.

## Structure
- Shared package cpu_pkg holds:
  - constants LANE_W=16, NUM_LANES=3, VEC_W=48;
  - typedef enum vst_state_t {IDLE, WA, WB, WC};
  - lane index helpers.
  Both the ALU and this unit use the same lane constants.
- Implement as a single module. Lane select is a small mux on state, with no sub-module.
- The address adder is ADDR_W bits wide and its carry is dropped.

## Test plan
- Vector store, ack tied high: req_data=48'h1111_2222_3333, addr=16'h0040. Required: writes (0040,1111), (0041,2222), (0042,3333) in cycles 1–3; done in cycle 4.
- Scalar store: req_vec=0, data=48'hAAAA_BBBB_CCCC, addr=16'h0100. Required: single write (0100,CCCC); done in cycle 2; lanes A and B are never driven with mem_we=1.
- Ack backpressure: vector store with mem_ack low for 2 cycles on lane B. Required: mem_addr=base+1 and mem_wdata=lane B held stable for 3 cycles; total latency 6 cycles to done.
- Address wrap: vector store at addr=16'hFFFF. Required: writes to FFFF, 0000, 0001.
- Reset mid-operation: assert rst while in WB.
  - Required next cycle: mem_we=0, req_ready=1, done=0.
  - Required afterwards: no WC write occurs, and a new request is accepted normally.
- Back-to-back with spurious ack: two vector requests are held valid continuously; mem_ack is pulsed while IDLE.
  - Required: the second request is accepted in the done cycle.
  - Required: the idle ack has no effect; the second store proceeds with 6 writes total in correct order.
